pipe_controller: RTL and testbench

Pipelined control unit for the 5-stage MIPS core. It decodes the instruction in the D stage with the team's `main_dec` and `alu_dec` decoders. It carries the decoded control word through the E, M and W pipeline registers, with flush and bubble handling. It also generates the multi-cycle stall for `div`/`divu` in E. The datapath consumes the per-stage outputs; the hazard unit supplies `flush_e` and consumes `div_busy`.

---
 rtl/pipe_controller.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_pipe_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// -----------------------------------------------------------------------------
// pipe_controller
//   Pipelined control unit for the 5-stage MIPS core. Decodes the D-stage
//   instruction (main_dec + alu_dec), carries the control word through the
//   E, M and W pipeline registers with flush/bubble handling, and raises a
//   multi-cycle stall while a div/divu occupies E.
//
//   Optional feature macro: HILO_DIV_EN
//     defined   : divide FSM, counter and div_busy hold/bubble logic present.
//     undefined : div_busy tied to 0; divides pass E in a single cycle.
//
// Ports
//   clk, rst_n            : rising-edge clock, async active-low reset
//   op_d, funct_d, rt_d   : D-stage instruction fields
//   flush_e               : load a bubble into E on the next edge
//   branch_d, jump_d,
//   jumpr_d               : combinational D-stage decode
//   alucontrol_e, alusrc_e,
//   regdst_e, write_al_e,
//   regwrite_e, memtoreg_e: E-stage controls
//   regwrite_m, memtoreg_m,
//   memwrite_m            : M-stage controls
//   regwrite_w, memtoreg_w: W-stage controls
//   div_busy              : stall request; datapath holds F, D and E
// -----------------------------------------------------------------------------

// Main decoder: register/memory/branch controls from opcode, funct and rt.
module main_dec (
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    output logic       regwrite,
    output logic       regdst,
    output logic       alusrc,
    output logic       memtoreg,
    output logic       memwrite,
    output logic       branch,
    output logic       jump,
    output logic       jumpr,
    output logic       write_al
);
    always_comb begin
        regwrite = 1'b0;
        regdst   = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        jumpr    = 1'b0;
        write_al = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    // shifts, mfhi/mflo, arithmetic/logic: write rd
                    6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                    6'b000111, 6'b010000, 6'b010010, 6'b100000, 6'b100001,
                    6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                    6'b100111, 6'b101010, 6'b101011: begin
                        regwrite = 1'b1;
                        regdst   = 1'b1;
                    end
                    6'b001000: jumpr = 1'b1;                        // jr
                    6'b001001: begin                                // jalr
                        jumpr    = 1'b1;
                        regwrite = 1'b1;
                        regdst   = 1'b1;
                        write_al = 1'b1;
                    end
                    // mthi/mtlo/mult/multu/div/divu touch only HI/LO
                    default: ;
                endcase
            end
            6'b000001: begin                                        // REGIMM
                case (rt)
                    5'b00000, 5'b00001: branch = 1'b1;              // bltz/bgez
                    5'b10000, 5'b10001: begin                       // bltzal/bgezal
                        branch   = 1'b1;
                        regwrite = 1'b1;
                        write_al = 1'b1;
                    end
                    default: ;
                endcase
            end
            6'b000010: jump = 1'b1;                                 // j
            6'b000011: begin                                        // jal
                jump     = 1'b1;
                regwrite = 1'b1;
                write_al = 1'b1;
            end
            6'b000100, 6'b000101, 6'b000110, 6'b000111: branch = 1'b1;
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin       // immediates
                regwrite = 1'b1;
                alusrc   = 1'b1;
            end
            6'b100011: begin                                        // lw
                regwrite = 1'b1;
                alusrc   = 1'b1;
                memtoreg = 1'b1;
            end
            6'b101011: begin                                        // sw
                alusrc   = 1'b1;
                memwrite = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// ALU decoder: ALU operation code from opcode and funct.
module alu_dec #(
    parameter int ALUCTRL_W = 8
) (
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alucontrol
);
    localparam logic [7:0] ALU_NOP   = 8'd0;
    localparam logic [7:0] ALU_ADD   = 8'd1;
    localparam logic [7:0] ALU_ADDU  = 8'd2;
    localparam logic [7:0] ALU_SUB   = 8'd3;
    localparam logic [7:0] ALU_SUBU  = 8'd4;
    localparam logic [7:0] ALU_AND   = 8'd5;
    localparam logic [7:0] ALU_OR    = 8'd6;
    localparam logic [7:0] ALU_XOR   = 8'd7;
    localparam logic [7:0] ALU_NOR   = 8'd8;
    localparam logic [7:0] ALU_SLT   = 8'd9;
    localparam logic [7:0] ALU_SLTU  = 8'd10;
    localparam logic [7:0] ALU_SLL   = 8'd11;
    localparam logic [7:0] ALU_SRL   = 8'd12;
    localparam logic [7:0] ALU_SRA   = 8'd13;
    localparam logic [7:0] ALU_SLLV  = 8'd14;
    localparam logic [7:0] ALU_SRLV  = 8'd15;
    localparam logic [7:0] ALU_SRAV  = 8'd16;
    localparam logic [7:0] ALU_LUI   = 8'd17;
    localparam logic [7:0] ALU_MULT  = 8'd18;
    localparam logic [7:0] ALU_MULTU = 8'd19;
    localparam logic [7:0] ALU_DIV   = 8'd20;
    localparam logic [7:0] ALU_DIVU  = 8'd21;
    localparam logic [7:0] ALU_MFHI  = 8'd22;
    localparam logic [7:0] ALU_MFLO  = 8'd23;
    localparam logic [7:0] ALU_MTHI  = 8'd24;
    localparam logic [7:0] ALU_MTLO  = 8'd25;

    logic [7:0] code;

    always_comb begin
        code = ALU_NOP;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b000000: code = ALU_SLL;
                    6'b000010: code = ALU_SRL;
                    6'b000011: code = ALU_SRA;
                    6'b000100: code = ALU_SLLV;
                    6'b000110: code = ALU_SRLV;
                    6'b000111: code = ALU_SRAV;
                    6'b010000: code = ALU_MFHI;
                    6'b010001: code = ALU_MTHI;
                    6'b010010: code = ALU_MFLO;
                    6'b010011: code = ALU_MTLO;
                    6'b011000: code = ALU_MULT;
                    6'b011001: code = ALU_MULTU;
                    6'b011010: code = ALU_DIV;
                    6'b011011: code = ALU_DIVU;
                    6'b100000: code = ALU_ADD;
                    6'b100001: code = ALU_ADDU;
                    6'b100010: code = ALU_SUB;
                    6'b100011: code = ALU_SUBU;
                    6'b100100: code = ALU_AND;
                    6'b100101: code = ALU_OR;
                    6'b100110: code = ALU_XOR;
                    6'b100111: code = ALU_NOR;
                    6'b101010: code = ALU_SLT;
                    6'b101011: code = ALU_SLTU;
                    default:   code = ALU_NOP;   // jr/jalr and unknown funct
                endcase
            end
            6'b000001, 6'b000100, 6'b000101,
            6'b000110, 6'b000111: code = ALU_SUB;  // branch compare
            6'b001000:            code = ALU_ADD;
            6'b001001:            code = ALU_ADDU;
            6'b001010:            code = ALU_SLT;
            6'b001011:            code = ALU_SLTU;
            6'b001100:            code = ALU_AND;
            6'b001101:            code = ALU_OR;
            6'b001110:            code = ALU_XOR;
            6'b001111:            code = ALU_LUI;
            6'b100011, 6'b101011: code = ALU_ADD;  // address generation
            default:              code = ALU_NOP;
        endcase
    end

    assign alucontrol = ALUCTRL_W'(code);
endmodule

module pipe_controller #(
    parameter int ALUCTRL_W  = 8,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           op_d,
    input  logic [5:0]           funct_d,
    input  logic [4:0]           rt_d,
    input  logic                 flush_e,
    output logic                 branch_d,
    output logic                 jump_d,
    output logic                 jumpr_d,
    output logic [ALUCTRL_W-1:0] alucontrol_e,
    output logic                 alusrc_e,
    output logic                 regdst_e,
    output logic                 write_al_e,
    output logic                 regwrite_e,
    output logic                 memtoreg_e,
    output logic                 regwrite_m,
    output logic                 memtoreg_m,
    output logic                 memwrite_m,
    output logic                 regwrite_w,
    output logic                 memtoreg_w,
    output logic                 div_busy
);
    if (DIV_CYCLES < 2 || CNT_W < $clog2(DIV_CYCLES)) begin : g_bad_cfg
        $error("pipe_controller: DIV_CYCLES must be >= 2 and CNT_W wide enough");
    end

    typedef struct packed {
        logic [ALUCTRL_W-1:0] alucontrol;
        logic                 alusrc;
        logic                 regdst;
        logic                 write_al;
        logic                 regwrite;
        logic                 memtoreg;
        logic                 memwrite;
    } ctrl_e_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ctrl_m_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } ctrl_w_t;

    logic                 dec_regwrite, dec_regdst, dec_alusrc, dec_memtoreg;
    logic                 dec_memwrite, dec_write_al;
    logic [ALUCTRL_W-1:0] dec_alucontrol;
    ctrl_e_t              ctrl_d;
    ctrl_e_t              ctrl_p1;
    ctrl_m_t              ctrl_p2;
    ctrl_w_t              ctrl_p3;

    // ---- D stage: combinational decode ----
    main_dec u_main_dec (
        .op       (op_d),
        .funct    (funct_d),
        .rt       (rt_d),
        .regwrite (dec_regwrite),
        .regdst   (dec_regdst),
        .alusrc   (dec_alusrc),
        .memtoreg (dec_memtoreg),
        .memwrite (dec_memwrite),
        .branch   (branch_d),
        .jump     (jump_d),
        .jumpr    (jumpr_d),
        .write_al (dec_write_al)
    );

    alu_dec #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
        .op         (op_d),
        .funct      (funct_d),
        .alucontrol (dec_alucontrol)
    );

    always_comb begin
        ctrl_d            = '0;
        ctrl_d.alucontrol = dec_alucontrol;
        ctrl_d.alusrc     = dec_alusrc;
        ctrl_d.regdst     = dec_regdst;
        ctrl_d.write_al   = dec_write_al;
        ctrl_d.regwrite   = dec_regwrite;
        ctrl_d.memtoreg   = dec_memtoreg;
        ctrl_d.memwrite   = dec_memwrite;
    end

`ifdef HILO_DIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    logic             is_div_d;
    logic             is_div_p1;
    div_state_t       state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    assign is_div_d = (op_d == 6'b000000) &&
                      ((funct_d == 6'b011010) || (funct_d == 6'b011011));
`else
    assign div_busy = 1'b0;
`endif

    // ---- D/E boundary: hold during a divide, else flush, else load ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_p1   <= '0;
`ifdef HILO_DIV_EN
            is_div_p1 <= 1'b0;
`endif
        end else if (!div_busy) begin
            if (flush_e) begin
                ctrl_p1   <= '0;
`ifdef HILO_DIV_EN
                is_div_p1 <= 1'b0;
`endif
            end else begin
                ctrl_p1   <= ctrl_d;
`ifdef HILO_DIV_EN
                is_div_p1 <= is_div_d;
`endif
            end
        end
    end

`ifdef HILO_DIV_EN
    // Divide occupancy: IDLE covers the first stall cycle, BUSY counts the
    // remaining DIV_CYCLES-1, DONE releases E for one advancing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        div_busy  = 1'b0;
        case (state_q)
            IDLE: begin
                div_busy = is_div_p1;
                if (is_div_p1) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_W'(DIV_CYCLES - 2);
                end
            end
            BUSY: begin
                div_busy = 1'b1;
                if (cnt_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end
`endif

    // ---- E/M boundary: bubble while E is held ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_p2 <= '0;
        end else if (div_busy) begin
            ctrl_p2 <= '0;
        end else begin
            ctrl_p2.regwrite <= ctrl_p1.regwrite;
            ctrl_p2.memtoreg <= ctrl_p1.memtoreg;
            ctrl_p2.memwrite <= ctrl_p1.memwrite;
        end
    end

    // ---- M/W boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_p3 <= '0;
        end else begin
            ctrl_p3.regwrite <= ctrl_p2.regwrite;
            ctrl_p3.memtoreg <= ctrl_p2.memtoreg;
        end
    end

    assign alucontrol_e = ctrl_p1.alucontrol;
    assign alusrc_e     = ctrl_p1.alusrc;
    assign regdst_e     = ctrl_p1.regdst;
    assign write_al_e   = ctrl_p1.write_al;
    assign regwrite_e   = ctrl_p1.regwrite;
    assign memtoreg_e   = ctrl_p1.memtoreg;
    assign regwrite_m   = ctrl_p2.regwrite;
    assign memtoreg_m   = ctrl_p2.memtoreg;
    assign memwrite_m   = ctrl_p2.memwrite;
    assign regwrite_w   = ctrl_p3.regwrite;
    assign memtoreg_w   = ctrl_p3.memtoreg;
endmodule

// File: tb/tb_pipe_controller.sv
`timescale 1ns/1ps
module tb_pipe_controller;
    localparam int ALUCTRL_W  = 8;
    localparam int DIV_CYCLES = 4;

    localparam logic [7:0] ALU_NOP  = 8'd0;
    localparam logic [7:0] ALU_ADD  = 8'd1;
    localparam logic [7:0] ALU_DIV  = 8'd20;
    localparam logic [7:0] ALU_DIVU = 8'd21;

    localparam logic [5:0] OP_R      = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BAD    = 6'b111111;
    localparam logic [5:0] F_ADD     = 6'b100000;
    localparam logic [5:0] F_JR      = 6'b001000;
    localparam logic [5:0] F_DIV     = 6'b011010;
    localparam logic [5:0] F_DIVU    = 6'b011011;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [5:0]           op_d = 6'b0;
    logic [5:0]           funct_d = 6'b0;
    logic [4:0]           rt_d = 5'b0;
    logic                 flush_e = 1'b0;
    logic                 branch_d, jump_d, jumpr_d;
    logic [ALUCTRL_W-1:0] alucontrol_e;
    logic                 alusrc_e, regdst_e, write_al_e, regwrite_e, memtoreg_e;
    logic                 regwrite_m, memtoreg_m, memwrite_m;
    logic                 regwrite_w, memtoreg_w;
    logic                 div_busy;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_controller #(
        .ALUCTRL_W  (ALUCTRL_W),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_d         (op_d),
        .funct_d      (funct_d),
        .rt_d         (rt_d),
        .flush_e      (flush_e),
        .branch_d     (branch_d),
        .jump_d       (jump_d),
        .jumpr_d      (jumpr_d),
        .alucontrol_e (alucontrol_e),
        .alusrc_e     (alusrc_e),
        .regdst_e     (regdst_e),
        .write_al_e   (write_al_e),
        .regwrite_e   (regwrite_e),
        .memtoreg_e   (memtoreg_e),
        .regwrite_m   (regwrite_m),
        .memtoreg_m   (memtoreg_m),
        .memwrite_m   (memwrite_m),
        .regwrite_w   (regwrite_w),
        .memtoreg_w   (memtoreg_w),
        .div_busy     (div_busy)
    );

    always #5 clk = ~clk;

    logic [31:0] all_out;
    logic [31:0] e_fields;
    assign all_out  = 32'({branch_d, jump_d, jumpr_d, alucontrol_e, alusrc_e,
                           regdst_e, write_al_e, regwrite_e, memtoreg_e,
                           regwrite_m, memtoreg_m, memwrite_m, regwrite_w,
                           memtoreg_w, div_busy});
    assign e_fields = 32'({alucontrol_e, alusrc_e, regdst_e, write_al_e,
                           regwrite_e, memtoreg_e});

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] funct, input logic [4:0] rt);
        op_d    = op;
        funct_d = funct;
        rt_d    = rt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset with lw in D
        set_instr(OP_LW, 6'b0, 5'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_all_zero", all_out, 32'h0);
        rst_n = 1'b1;
        step();
        check_eq("lw_regwrite_e", 32'(regwrite_e), 32'd1);
        check_eq("lw_memtoreg_e", 32'(memtoreg_e), 32'd1);
        check_eq("lw_alusrc_e", 32'(alusrc_e), 32'd1);
        check_eq("lw_alucontrol_e", 32'(alucontrol_e), 32'(ALU_ADD));

        // Combinational D-stage decode
        set_instr(OP_BEQ, 6'b0, 5'b0);
        #1;
        check_eq("beq_branch_d", 32'({branch_d, jump_d, jumpr_d}), 32'b100);
        set_instr(OP_J, 6'b0, 5'b0);
        #1;
        check_eq("j_jump_d", 32'({branch_d, jump_d, jumpr_d}), 32'b010);
        set_instr(OP_R, F_JR, 5'b0);
        #1;
        check_eq("jr_jumpr_d", 32'({branch_d, jump_d, jumpr_d}), 32'b001);

        // Flow: add, sw, lw on consecutive cycles
        set_instr(OP_R, F_ADD, 5'b0);
        step();                                   // edge 1
        check_eq("add_e_regdst", 32'({regwrite_e, regdst_e}), 32'b11);
        set_instr(OP_SW, 6'b0, 5'b0);
        step();                                   // edge 2
        set_instr(OP_LW, 6'b0, 5'b0);
        step();                                   // edge 3
        check_eq("add_regwrite_w_e3", 32'(regwrite_w), 32'd1);
        check_eq("sw_memwrite_m_e3", 32'(memwrite_m), 32'd1);
        check_eq("add_memtoreg_w_e3", 32'(memtoreg_w), 32'd0);
        set_instr(OP_BAD, 6'b0, 5'b0);
        step();                                   // edge 4
        check_eq("lw_memtoreg_m_e4", 32'({memtoreg_m, memwrite_m}), 32'b10);
        check_eq("sw_regwrite_w_e4", 32'(regwrite_w), 32'd0);
        step();                                   // edge 5
        check_eq("lw_memtoreg_w_e5", 32'({regwrite_w, memtoreg_w}), 32'b11);

        // Unknown opcode decodes to nothing
        check_eq("bad_d_zero", 32'({branch_d, jump_d, jumpr_d}), 32'b000);
        check_eq("bad_e_zero", e_fields, 32'h0);

        // bgezal: branch with link
        set_instr(OP_REGIMM, 6'b0, 5'b10001);
        #1;
        check_eq("bgezal_branch_d", 32'(branch_d), 32'd1);
        step();
        check_eq("bgezal_link_e", 32'({write_al_e, regwrite_e, regdst_e}), 32'b110);
        set_instr(OP_BAD, 6'b0, 5'b0);
        repeat (3) step();

        // Flush: bubble travels E -> M -> W, following add flows normally
        set_instr(OP_R, F_ADD, 5'b0);
        flush_e = 1'b1;
        step();
        check_eq("flush_e_bubble", e_fields, 32'h0);
        flush_e = 1'b0;
        step();
        check_eq("flush_m_bubble", 32'(regwrite_m), 32'd0);
        check_eq("flush_next_add_e", 32'(regwrite_e), 32'd1);
        set_instr(OP_BAD, 6'b0, 5'b0);
        step();
        check_eq("flush_w_bubble", 32'(regwrite_w), 32'd0);
        check_eq("flush_next_add_m", 32'(regwrite_m), 32'd1);
        step();
        check_eq("flush_next_add_w", 32'(regwrite_w), 32'd1);

`ifdef HILO_DIV_EN
        // Single divide preceded by an add
        set_instr(OP_R, F_ADD, 5'b0);
        step();
        set_instr(OP_R, F_DIV, 5'b0);
        step();                                   // div enters E
        check_eq("div_busy_rise", 32'(div_busy), 32'd1);
        check_eq("div_add_in_m", 32'(regwrite_m), 32'd1);
        set_instr(OP_BAD, 6'b0, 5'b0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check_eq($sformatf("div_busy_c%0d", i + 1), 32'(div_busy), 32'd1);
            check_eq($sformatf("div_alu_hold_c%0d", i + 1), 32'(alucontrol_e), 32'(ALU_DIV));
            check_eq($sformatf("div_m_bubble_c%0d", i + 1), 32'(regwrite_m), 32'd0);
        end
        step();                                   // DONE
        check_eq("div_done_busy", 32'(div_busy), 32'd0);
        check_eq("div_done_alu", 32'(alucontrol_e), 32'(ALU_DIV));
        check_eq("div_done_m_bubble", 32'(regwrite_m), 32'd0);
        step();                                   // 5th edge: E advances
        check_eq("div_left_e", 32'(alucontrol_e), 32'(ALU_NOP));
        check_eq("div_after_busy", 32'(div_busy), 32'd0);

        // Back-to-back divu: 1,1,1,1,0,1,1,1,1,0
        set_instr(OP_R, F_DIVU, 5'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 5) set_instr(OP_BAD, 6'b0, 5'b0);
            check_eq($sformatf("b2b_busy_%0d", i), 32'(div_busy),
                     (i == 4 || i == 9) ? 32'd0 : 32'd1);
        end
        check_eq("b2b_alu_hold", 32'(alucontrol_e), 32'(ALU_DIVU));
        step();
        check_eq("b2b_done", 32'({div_busy, alucontrol_e}), 32'h0);

        // Reset in BUSY with cnt == 1
        set_instr(OP_R, F_DIV, 5'b0);
        step();
        set_instr(OP_BAD, 6'b0, 5'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 32'(div_busy), 32'd0);
        check_eq("rst_mid_all_zero", all_out, 32'h0);
        step();
        rst_n = 1'b1;
        set_instr(OP_R, F_DIV, 5'b0);
        step();
        set_instr(OP_BAD, 6'b0, 5'b0);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("rst_redo_busy_%0d", i), 32'(div_busy),
                     (i == 4) ? 32'd0 : 32'd1);
            step();
        end
`else
        // Divide is an ordinary single-cycle E instruction
        set_instr(OP_R, F_ADD, 5'b0);
        step();
        set_instr(OP_R, F_DIV, 5'b0);
        step();
        check_eq("nodiv_busy", 32'(div_busy), 32'd0);
        check_eq("nodiv_alu_e", 32'(alucontrol_e), 32'(ALU_DIV));
        check_eq("nodiv_add_m", 32'(regwrite_m), 32'd1);
        set_instr(OP_BAD, 6'b0, 5'b0);
        step();
        check_eq("nodiv_left_e", 32'(alucontrol_e), 32'(ALU_NOP));
        check_eq("nodiv_busy2", 32'(div_busy), 32'd0);
        check_eq("nodiv_add_w", 32'(regwrite_w), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
